// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser
// Function : Greedy $20/$10/$5 coin payout via hopper handshake, with
//            per-denomination inventory and shortfall reporting.
// Options  : HOPPER_TIMEOUT_EN - abort a coin when the hopper never acks.
// Revision : 1.0 - initial release
// ============================================================================
module change_dispenser #(
  parameter int CNT_W          = 8,
  parameter int INIT_COUNT     = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       change_amount,
  input  logic             change_valid,
  input  logic             refill,
  input  logic [1:0]       refill_denom,
  input  logic [CNT_W-1:0] refill_qty,
  input  logic             hopper_ack,
  output logic [2:0]       coin_eject,
  output logic             busy,
  output logic             dispense_done,
  output logic [6:0]       shortfall,
  output logic [CNT_W-1:0] cnt_5,
  output logic [CNT_W-1:0] cnt_10,
  output logic [CNT_W-1:0] cnt_20,
  output logic             fault
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_SELECT = 2'd1;
  localparam logic [1:0] c_EJECT  = 2'd2;
  localparam logic [1:0] c_DONE   = 2'd3;

  localparam logic [CNT_W:0]   c_CNT_MAX  = {1'b0, {CNT_W{1'b1}}};
  localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'(INIT_COUNT);

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]       r_state;
  logic [6:0]       r_remaining;
  logic [2:0]       r_eject;
  logic             r_done;
  logic [6:0]       r_shortfall;
  logic [CNT_W-1:0] r_cnt [3];
  logic [CNT_W:0]   w_sum [3];
  logic [2:0]       w_pick;
  logic [6:0]       w_coin_value;
  logic             w_ack_ok;
  logic             w_timeout;

  // Selection uses registered counts, so a refill landing in SELECT is
  // only visible to the following SELECT.
  always_comb begin
    w_pick = 3'b000;
    if (r_remaining >= 7'd20 && r_cnt[2] != '0)
      w_pick = 3'b100;
    else if (r_remaining >= 7'd10 && r_cnt[1] != '0)
      w_pick = 3'b010;
    else if (r_remaining >= 7'd5 && r_cnt[0] != '0)
      w_pick = 3'b001;
  end

  always_comb begin
    w_coin_value = 7'd0;
    case (r_eject)
      3'b100:  w_coin_value = 7'd20;
      3'b010:  w_coin_value = 7'd10;
      3'b001:  w_coin_value = 7'd5;
      default: w_coin_value = 7'd0;
    endcase
  end

  assign w_ack_ok = (r_state == c_EJECT) && hopper_ack;

`ifdef HOPPER_TIMEOUT_EN
  localparam int c_TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_TMR_W-1:0] r_timer;
  logic               r_fault;

  // An ack arriving on the final cycle takes priority over the timeout.
  assign w_timeout = (r_state == c_EJECT) && !hopper_ack &&
                     (r_timer == c_TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_timer <= '0;
      r_fault <= 1'b0;
    end else begin
      if (r_state != c_EJECT)
        r_timer <= '0;
      else if (!hopper_ack)
        r_timer <= r_timer + 1'b1;
      if (w_timeout)
        r_fault <= 1'b1;
    end
  end

  assign fault = r_fault;
`else
  assign w_timeout = 1'b0;
  assign fault     = 1'b0;
`endif

  // Refill and ack-decrement may hit the same counter on one edge; the
  // extra MSB absorbs the sum before saturation.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_sum[i] = {1'b0, r_cnt[i]};
      if (refill && refill_denom == 2'(i))
        w_sum[i] = w_sum[i] + {1'b0, refill_qty};
      if (w_ack_ok && r_eject[i])
        w_sum[i] = w_sum[i] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset)
        r_cnt[i] <= c_CNT_INIT;
      else if (w_sum[i] > c_CNT_MAX)
        r_cnt[i] <= '1;
      else
        r_cnt[i] <= w_sum[i][CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= c_IDLE;
      r_remaining <= 7'd0;
      r_eject     <= 3'b000;
      r_done      <= 1'b0;
      r_shortfall <= 7'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (change_valid) begin
            r_remaining <= change_amount;
            r_shortfall <= 7'd0;
            r_state     <= (change_amount != 7'd0) ? c_SELECT : c_DONE;
          end
        end
        c_SELECT: begin
          r_eject <= w_pick;
          r_state <= (w_pick != 3'b000) ? c_EJECT : c_DONE;
        end
        c_EJECT: begin
          if (hopper_ack) begin
            r_remaining <= r_remaining - w_coin_value;
            r_eject     <= 3'b000;
            r_state     <= c_SELECT;
          end else if (w_timeout) begin
            r_eject <= 3'b000;
            r_state <= c_DONE;
          end
        end
        c_DONE: begin
          r_done      <= 1'b1;
          r_shortfall <= r_remaining;
          r_state     <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign coin_eject    = r_eject;
  assign busy          = (r_state != c_IDLE);
  assign dispense_done = r_done;
  assign shortfall     = r_shortfall;
  assign cnt_5         = r_cnt[0];
  assign cnt_10        = r_cnt[1];
  assign cnt_20        = r_cnt[2];

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_change_dispenser
// Function : Directed, table-driven bench for change_dispenser.
// Revision : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] change_amount;
  logic       change_valid;
  logic       refill;
  logic [1:0] refill_denom;
  logic [7:0] refill_qty;
  logic       hopper_ack;
  logic [2:0] coin_eject;
  logic       busy;
  logic       dispense_done;
  logic [6:0] shortfall;
  logic [7:0] cnt_5, cnt_10, cnt_20;
  logic       fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  change_dispenser dut (
    .clk(clk), .reset(reset),
    .change_amount(change_amount), .change_valid(change_valid),
    .refill(refill), .refill_denom(refill_denom), .refill_qty(refill_qty),
    .hopper_ack(hopper_ack), .coin_eject(coin_eject), .busy(busy),
    .dispense_done(dispense_done), .shortfall(shortfall),
    .cnt_5(cnt_5), .cnt_10(cnt_10), .cnt_20(cnt_20), .fault(fault)
  );

  typedef struct {
    logic       ref_en;
    logic [1:0] ref_d;
    logic [7:0] ref_q;
    logic [6:0] amt;
    int         dly;
    int         e5, e10, e20;
    logic [6:0] esf;
    logic [7:0] c5, c10, c20;
  } vec_t;

  localparam int NV = 12;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait expired, got no event expected event", name);
  endtask

  task automatic reset_dut();
    reset = 1'b0; change_valid = 1'b0; change_amount = '0;
    refill = 1'b0; refill_denom = '0; refill_qty = '0; hopper_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_refill(input logic [1:0] d, input logic [7:0] q);
    refill = 1'b1; refill_denom = d; refill_qty = q;
    @(negedge clk);
    refill = 1'b0;
  endtask

  task automatic wait_eject(input string name, output bit ok);
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (coin_eject != 3'b000) ok = 1;
    end
    if (!ok) bound_fail(name);
  endtask

  task automatic wait_done(input string name, output bit ok);
    ok = 0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (dispense_done) ok = 1;
    end
    if (!ok) bound_fail(name);
  endtask

  // Issues one request, acks every coin after dly cycles, tallies coins.
  task automatic pay(input logic [6:0] amt, input int dly,
                     output int n5, output int n10, output int n20,
                     output logic [6:0] sf, output int first_cyc, output int done_cyc);
    int cyc;
    bit got_done;
    logic [2:0] held;
    n5 = 0; n10 = 0; n20 = 0; sf = '0; first_cyc = -1; done_cyc = -1; got_done = 0;
    change_amount = amt; change_valid = 1'b1;
    @(negedge clk);
    change_valid = 1'b0; cyc = 1;
    chk("shortfall_clear_on_accept", 32'(shortfall), 0);
    chk("busy_after_accept", 32'(busy), 1);
    while (!got_done && cyc < 3000) begin
      @(negedge clk); cyc++;
      if (dispense_done) begin
        got_done = 1; sf = shortfall; done_cyc = cyc;
      end else if (coin_eject != 3'b000) begin
        held = coin_eject;
        if (first_cyc < 0) first_cyc = cyc;
        chk("eject_onehot", 32'($countones(held)), 1);
        if (held[0]) n5++;
        if (held[1]) n10++;
        if (held[2]) n20++;
        repeat (dly) begin
          @(negedge clk); cyc++;
          chk("eject_stable", 32'(coin_eject), 32'(held));
        end
        hopper_ack = 1'b1;
        @(negedge clk); cyc++;
        hopper_ack = 1'b0;
        chk("eject_clear_on_ack", 32'(coin_eject), 0);
      end
    end
    if (!got_done) bound_fail("pay_done");
    else begin
      chk("busy_low_at_done", 32'(busy), 0);
      @(negedge clk);
      chk("done_one_cycle", 32'(dispense_done), 0);
    end
  endtask

  initial begin
    int n5, n10, n20, fc, dc, cnt;
    logic [6:0] sf;
    bit ok;

    vec[0]  = '{1'b0, 2'd0, 8'd0,  7'd15,  2, 1,  1, 0, 7'd0,  8'd9,  8'd9, 8'd10};
    vec[1]  = '{1'b0, 2'd0, 8'd0,  7'd100, 0, 0,  0, 5, 7'd0,  8'd9,  8'd9, 8'd5};
    vec[2]  = '{1'b0, 2'd0, 8'd0,  7'd100, 1, 0,  0, 5, 7'd0,  8'd9,  8'd9, 8'd0};
    vec[3]  = '{1'b0, 2'd0, 8'd0,  7'd30,  2, 0,  3, 0, 7'd0,  8'd9,  8'd6, 8'd0};
    vec[4]  = '{1'b0, 2'd0, 8'd0,  7'd7,   3, 1,  0, 0, 7'd2,  8'd8,  8'd6, 8'd0};
    vec[5]  = '{1'b0, 2'd0, 8'd0,  7'd0,   0, 0,  0, 0, 7'd0,  8'd8,  8'd6, 8'd0};
    vec[6]  = '{1'b0, 2'd0, 8'd0,  7'd127, 1, 8,  6, 0, 7'd27, 8'd0,  8'd0, 8'd0};
    vec[7]  = '{1'b1, 2'd2, 8'd1,  7'd35,  2, 0,  0, 1, 7'd15, 8'd0,  8'd0, 8'd0};
    vec[8]  = '{1'b1, 2'd0, 8'd20, 7'd7,   0, 1,  0, 0, 7'd2,  8'd19, 8'd0, 8'd0};
    vec[9]  = '{1'b1, 2'd1, 8'd3,  7'd3,   1, 0,  0, 0, 7'd3,  8'd19, 8'd3, 8'd0};
    vec[10] = '{1'b0, 2'd0, 8'd0,  7'd45,  2, 3,  3, 0, 7'd0,  8'd16, 8'd0, 8'd0};
    vec[11] = '{1'b1, 2'd2, 8'd2,  7'd125, 0, 16, 0, 2, 7'd5,  8'd0,  8'd0, 8'd0};

    reset_dut();
    chk("rst_coin_eject", 32'(coin_eject), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(dispense_done), 0);
    chk("rst_shortfall", 32'(shortfall), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_cnt_5", 32'(cnt_5), 10);
    chk("rst_cnt_10", 32'(cnt_10), 10);
    chk("rst_cnt_20", 32'(cnt_20), 10);

    for (int i = 0; i < NV; i++) begin
      if (vec[i].ref_en) do_refill(vec[i].ref_d, vec[i].ref_q);
      pay(vec[i].amt, vec[i].dly, n5, n10, n20, sf, fc, dc);
      chk($sformatf("v%0d_n5", i), 32'(n5), 32'(vec[i].e5));
      chk($sformatf("v%0d_n10", i), 32'(n10), 32'(vec[i].e10));
      chk($sformatf("v%0d_n20", i), 32'(n20), 32'(vec[i].e20));
      chk($sformatf("v%0d_shortfall", i), 32'(sf), 32'(vec[i].esf));
      chk($sformatf("v%0d_shortfall_hold", i), 32'(shortfall), 32'(vec[i].esf));
      chk($sformatf("v%0d_cnt_5", i), 32'(cnt_5), 32'(vec[i].c5));
      chk($sformatf("v%0d_cnt_10", i), 32'(cnt_10), 32'(vec[i].c10));
      chk($sformatf("v%0d_cnt_20", i), 32'(cnt_20), 32'(vec[i].c20));
      if (vec[i].e5 + vec[i].e10 + vec[i].e20 > 0)
        chk($sformatf("v%0d_first_eject_latency", i), 32'(fc), 2);
      if (vec[i].amt == 7'd0)
        chk($sformatf("v%0d_zero_done_latency", i), 32'(dc), 2);
    end

    // Request during EJECT is dropped; refill and ack collide on $10.
    reset_dut();
    change_amount = 7'd10; change_valid = 1'b1;
    @(negedge clk); change_valid = 1'b0;
    wait_eject("collide_eject", ok);
    chk("collide_eject_10", 32'(coin_eject), 32'(3'b010));
    change_amount = 7'd50; change_valid = 1'b1;
    @(negedge clk); change_valid = 1'b0;
    chk("ignored_req_eject_held", 32'(coin_eject), 32'(3'b010));
    hopper_ack = 1'b1; refill = 1'b1; refill_denom = 2'd1; refill_qty = 8'd5;
    @(negedge clk);
    hopper_ack = 1'b0; refill = 1'b0;
    chk("collide_cnt_10", 32'(cnt_10), 14);
    wait_done("collide_done", ok);
    if (ok) chk("collide_shortfall", 32'(shortfall), 0);
    repeat (6) @(negedge clk);
    chk("ignored_req_busy", 32'(busy), 0);
    chk("ignored_req_no_eject", 32'(coin_eject), 0);
    chk("ignored_req_cnt_20", 32'(cnt_20), 10);

    // Saturation and the unused refill code.
    do_refill(2'd0, 8'd250);
    chk("sat_cnt_5", 32'(cnt_5), 255);
    do_refill(2'd3, 8'd7);
    chk("denom3_cnt_5", 32'(cnt_5), 255);
    chk("denom3_cnt_10", 32'(cnt_10), 14);
    chk("denom3_cnt_20", 32'(cnt_20), 10);
    do_refill(2'd2, 8'd200);
    chk("no_sat_cnt_20", 32'(cnt_20), 210);

    // Reset in the middle of a payout.
    change_amount = 7'd20; change_valid = 1'b1;
    @(negedge clk); change_valid = 1'b0;
    wait_eject("midrst_eject", ok);
    chk("midrst_eject_20", 32'(coin_eject), 32'(3'b100));
    reset = 1'b0; hopper_ack = 1'b1;
    @(negedge clk);
    hopper_ack = 1'b0;
    chk("midrst_coin_eject", 32'(coin_eject), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(dispense_done), 0);
    chk("midrst_cnt_5", 32'(cnt_5), 10);
    chk("midrst_cnt_10", 32'(cnt_10), 10);
    chk("midrst_cnt_20", 32'(cnt_20), 10);
    reset = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (dispense_done || busy) cnt++;
    end
    chk("midrst_stays_idle", 32'(cnt), 0);

`ifdef HOPPER_TIMEOUT_EN
    change_amount = 7'd20; change_valid = 1'b1;
    @(negedge clk); change_valid = 1'b0;
    wait_eject("to_eject", ok);
    cnt = 1;
    for (int k = 0; k < 200 && coin_eject != 3'b000; k++) begin
      @(negedge clk);
      if (coin_eject != 3'b000) cnt++;
    end
    chk("to_eject_cycles", 32'(cnt), 64);
    chk("to_fault", 32'(fault), 1);
    wait_done("to_done", ok);
    if (ok) chk("to_shortfall", 32'(shortfall), 20);
    chk("to_cnt_20", 32'(cnt_20), 10);
    repeat (5) @(negedge clk);
    chk("to_fault_sticky", 32'(fault), 1);
`else
    change_amount = 7'd20; change_valid = 1'b1;
    @(negedge clk); change_valid = 1'b0;
    wait_eject("wait_eject", ok);
    repeat (100) @(negedge clk);
    chk("nto_eject_held", 32'(coin_eject), 32'(3'b100));
    chk("nto_fault", 32'(fault), 0);
    hopper_ack = 1'b1;
    @(negedge clk); hopper_ack = 1'b0;
    wait_done("nto_done", ok);
    if (ok) chk("nto_shortfall", 32'(shortfall), 0);
    chk("nto_cnt_20", 32'(cnt_20), 9);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
